icb_sram_slave: RTL and testbench



---
 rtl/icb_sram_slave_pkg.sv | 23 ++
 rtl/sram_1rw_be.sv | 33 +++
 rtl/icb_sram_slave.sv | 108 ++++++++++
 tb/tb_icb_sram_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icb_sram_slave_pkg.sv
// rtl/icb_sram_slave_pkg.sv - shared constants, FSM encoding and log2 helper for the ICB SRAM slave
package icb_sram_slave_pkg;

  localparam int ICB_ADDR_W = 32;
  localparam int ICB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Ceiling log2, bounded loop so it elaborates as a constant function.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// rtl/sram_1rw_be.sv - single-port synchronous SRAM with byte-lane write enables
module sram_1rw_be
  import icb_sram_slave_pkg::*;
#(
  parameter int DATA_W      = ICB_DATA_W,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = log2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Read data only changes on an enabled read, so it holds until the next access.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_W/8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/icb_sram_slave.sv
// rtl/icb_sram_slave.sv - ICB responder backed by byte-maskable SRAM with programmable wait states
module icb_sram_slave
  import icb_sram_slave_pkg::*;
#(
  parameter int                ADDR_W      = ICB_ADDR_W,
  parameter int                DATA_W      = ICB_DATA_W,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                WAIT_CYC    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                icb_cmd_vld,
  output logic                icb_cmd_rdy,
  input  logic [ADDR_W-1:0]   icb_cmd_addr,
  input  logic                icb_cmd_read,
  input  logic [DATA_W-1:0]   icb_cmd_wdata,
  input  logic [DATA_W/8-1:0] icb_cmd_wmask,
  output logic [DATA_W-1:0]   icb_rsp_rdata,
  output logic                icb_rsp_err,
  output logic                icb_rsp_vld,
  input  logic                icb_rsp_rdy
);

  localparam int                MASK_W    = DATA_W / 8;
  localparam int                LSB_W     = log2(MASK_W);
  localparam int                IDX_W     = log2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(DEPTH_WORDS * MASK_W);
  localparam logic [3:0]        WAIT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wait_cnt;
  logic              cmd_hs;
  logic              rsp_hs;
  logic [ADDR_W-1:0] off;
  logic              dec_err;
  logic [IDX_W-1:0]  word_idx;
  logic              rd_ok_q;
  logic              err_q;
  logic [DATA_W-1:0] sram_rdata;

  assign cmd_hs = icb_cmd_vld & icb_cmd_rdy;
  assign rsp_hs = icb_rsp_vld & icb_rsp_rdy;

  assign off      = icb_cmd_addr - BASE_ADDR;
  assign dec_err  = (icb_cmd_addr < BASE_ADDR) | (off >= SPAN) | (|icb_cmd_addr[LSB_W-1:0]);
  assign word_idx = off[LSB_W +: IDX_W];

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_hs) state_nxt = (WAIT_CYC == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    icb_cmd_rdy = (state == ST_IDLE);
    icb_rsp_vld = (state == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= 4'd0;
    end else if (cmd_hs) begin
      wait_cnt <= WAIT_INIT;
    end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Response attributes only change on a command handshake, keeping them stable through RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (cmd_hs) begin
      rd_ok_q <= icb_cmd_read & ~dec_err;
      err_q   <= dec_err;
    end
  end

  assign icb_rsp_err   = err_q;
  assign icb_rsp_rdata = rd_ok_q ? sram_rdata : '0;

  sram_1rw_be #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (IDX_W)
  ) u_sram (
    .clk   (clk),
    .en    (cmd_hs & ~dec_err),
    .we    (~icb_cmd_read),
    .be    (icb_cmd_wmask),
    .addr  (word_idx),
    .wdata (icb_cmd_wdata),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_icb_sram_slave.sv
// tb/tb_icb_sram_slave.sv - directed and random self-checking bench for icb_sram_slave
module tb_icb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_vld   [2];
  logic        cmd_rdy   [2];
  logic [31:0] cmd_addr  [2];
  logic        cmd_read  [2];
  logic [31:0] cmd_wdata [2];
  logic [3:0]  cmd_wmask [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        rsp_vld   [2];
  logic        rsp_rdy   [2];

  int checks = 0;
  int fails  = 0;
  int outstanding = 0;
  int spurious = 0;

  always #5 clk = ~clk;

  icb_sram_slave #(.WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .icb_cmd_vld(cmd_vld[0]), .icb_cmd_rdy(cmd_rdy[0]), .icb_cmd_addr(cmd_addr[0]),
    .icb_cmd_read(cmd_read[0]), .icb_cmd_wdata(cmd_wdata[0]), .icb_cmd_wmask(cmd_wmask[0]),
    .icb_rsp_rdata(rsp_rdata[0]), .icb_rsp_err(rsp_err[0]), .icb_rsp_vld(rsp_vld[0]),
    .icb_rsp_rdy(rsp_rdy[0])
  );

  icb_sram_slave #(.WAIT_CYC(3)) dut3 (
    .clk(clk), .rst(rst),
    .icb_cmd_vld(cmd_vld[1]), .icb_cmd_rdy(cmd_rdy[1]), .icb_cmd_addr(cmd_addr[1]),
    .icb_cmd_read(cmd_read[1]), .icb_cmd_wdata(cmd_wdata[1]), .icb_cmd_wmask(cmd_wmask[1]),
    .icb_rsp_rdata(rsp_rdata[1]), .icb_rsp_err(rsp_err[1]), .icb_rsp_vld(rsp_vld[1]),
    .icb_rsp_rdy(rsp_rdy[1])
  );

  // Responses on the zero-wait instance must always follow an accepted command.
  always @(posedge clk) begin
    if (!rst) begin
      outstanding <= 0;
    end else begin
      if (rsp_vld[0] && outstanding == 0) spurious <= spurious + 1;
      outstanding <= outstanding + ((cmd_vld[0] && cmd_rdy[0]) ? 1 : 0)
                                 - ((rsp_vld[0] && rsp_rdy[0]) ? 1 : 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_cmd(input int s, input logic [31:0] addr, input logic rd,
                        input logic [31:0] wd, input logic [3:0] wm,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    cmd_vld[s] = 1'b1; cmd_addr[s] = addr; cmd_read[s] = rd;
    cmd_wdata[s] = wd; cmd_wmask[s] = wm;
    guard = 0;
    while (cmd_rdy[s] !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    cmd_vld[s] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_vld[s] !== 1'b1 && lat < 100);
    if (rsp_vld[s] !== 1'b1) lat = -1;
    rdata = rsp_rdata[s];
    err   = rsp_err[s];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      cmd_vld[s] = 0; cmd_addr[s] = 0; cmd_read[s] = 0;
      cmd_wdata[s] = 0; cmd_wmask[s] = 0; rsp_rdy[s] = 1;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (rsp_vld[s] !== 1'b0) begin fails++; $display("FAIL reset_rsp_vld[%0d]: got %0b expected 0", s, rsp_vld[s]); end
      checks++;
      if (rsp_err[s] !== 1'b0) begin fails++; $display("FAIL reset_rsp_err[%0d]: got %0b expected 0", s, rsp_err[s]); end
      checks++;
      if (rsp_rdata[s] !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata[%0d]: got %h expected 0", s, rsp_rdata[s]); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (cmd_rdy[s] !== 1'b1) begin fails++; $display("FAIL post_reset_cmd_rdy[%0d]: got %0b expected 1", s, cmd_rdy[s]); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    do_cmd(0, 32'h8000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL wr_rsp: got err %0b rdata %h expected err 0 rdata 0", er, rd); end
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL wr_latency: got %0d expected 1", lat); end
    do_cmd(0, 32'h8000_0010, 1'b1, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin fails++; $display("FAIL rd_data: got %h err %0b expected deadbeef err 0", rd, er); end
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL rd_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; logic er; int lat;
    do_cmd(0, 32'h8000_0010, 1'b0, 32'h1122_3344, 4'b0101, rd, er, lat);
    do_cmd(0, 32'h8000_0010, 1'b1, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDE22_BE44) begin fails++; $display("FAIL byte_mask: got %h expected de22be44", rd); end
    do_cmd(0, 32'h8000_0010, 1'b0, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin fails++; $display("FAIL zero_mask_err: got %0b expected 0", er); end
    do_cmd(0, 32'h8000_0010, 1'b1, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDE22_BE44) begin fails++; $display("FAIL zero_mask_data: got %h expected de22be44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_cmd(0, 32'h7FFF_FFFC, 1'b1, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL below_base: got err %0b rdata %h expected err 1 rdata 0", er, rd); end
    do_cmd(0, 32'h8000_0FFC, 1'b0, 32'h0BAD_C0DE, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin fails++; $display("FAIL top_word_wr_err: got %0b expected 0", er); end
    do_cmd(0, 32'h8000_1000, 1'b0, 32'h5555_AAAA, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL past_end_wr: got err %0b rdata %h expected err 1 rdata 0", er, rd); end
    do_cmd(0, 32'h8000_0FFC, 1'b1, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0BAD_C0DE) begin fails++; $display("FAIL top_word_rd: got err %0b rdata %h expected err 0 rdata 0badc0de", er, rd); end
    do_cmd(0, 32'h8000_0002, 1'b1, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL misaligned: got err %0b rdata %h expected err 1 rdata 0", er, rd); end
  endtask

  task automatic test_wait_backpressure();
    logic [31:0] rd; logic er; int lat;
    do_cmd(1, 32'h8000_0020, 1'b0, 32'h1234_5678, 4'hF, rd, er, lat);
    checks++;
    if (lat !== 4 || er !== 1'b0) begin fails++; $display("FAIL wait_wr: got latency %0d err %0b expected 4 and 0", lat, er); end
    @(negedge clk);
    rsp_rdy[1] = 1'b0;
    cmd_vld[1] = 1'b1; cmd_addr[1] = 32'h8000_0020; cmd_read[1] = 1'b1;
    @(posedge clk); #1;
    cmd_vld[1] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      checks++;
      if (cmd_rdy[1] !== 1'b0) begin fails++; $display("FAIL wait_cmd_rdy: got %0b expected 0 at cycle %0d", cmd_rdy[1], lat); end
    end while (rsp_vld[1] !== 1'b1 && lat < 20);
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL wait_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_vld[1] !== 1'b1 || rsp_rdata[1] !== 32'h1234_5678 || rsp_err[1] !== 1'b0)
        begin fails++; $display("FAIL hold_rsp: got vld %0b rdata %h err %0b expected 1 12345678 0", rsp_vld[1], rsp_rdata[1], rsp_err[1]); end
      checks++;
      if (cmd_rdy[1] !== 1'b0) begin fails++; $display("FAIL hold_cmd_rdy: got %0b expected 0", cmd_rdy[1]); end
      @(negedge clk);
    end
    rsp_rdy[1] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_vld[1] !== 1'b0 || cmd_rdy[1] !== 1'b1) begin fails++; $display("FAIL after_rsp_hs: got vld %0b cmd_rdy %0b expected 0 1", rsp_vld[1], cmd_rdy[1]); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic er; int lat;
    do_cmd(1, 32'h8000_0040, 1'b0, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    @(negedge clk);
    cmd_vld[1] = 1'b1; cmd_addr[1] = 32'h8000_0040; cmd_read[1] = 1'b1;
    @(posedge clk); #1;
    cmd_vld[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_vld[1] !== 1'b0 || cmd_rdy[1] !== 1'b1) begin fails++; $display("FAIL midop_reset: got vld %0b cmd_rdy %0b expected 0 1", rsp_vld[1], cmd_rdy[1]); end
    @(negedge clk);
    rst = 1'b1;
    do_cmd(1, 32'h8000_0040, 1'b1, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0 || lat !== 4) begin fails++; $display("FAIL post_reset_rd: got %h err %0b lat %0d expected cafef00d 0 4", rd, er, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [16];
    logic [31:0] rd, addr, wd, exp_rd; logic er, rdsel, exp_err; logic [3:0] wm; int lat, kind, idx;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      do_cmd(0, 32'h8000_0000 + 32'(i * 4), 1'b0, model[i], 4'hF, rd, er, lat);
    end
    for (int n = 0; n < 1000; n++) begin
      kind = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      rdsel = 1'($urandom_range(0, 1));
      wd = $urandom;
      wm = 4'($urandom_range(0, 15));
      exp_err = 1'b1;
      case (kind)
        0: addr = 32'h8000_0000 + 32'(idx * 4) + 32'($urandom_range(1, 3));
        1: addr = 32'h8000_1000 + 32'($urandom_range(0, 255) * 4);
        2: addr = 32'h7FFF_F000 + 32'(idx * 4);
        3: addr = 32'hFFFF_FFFC;
        default: begin addr = 32'h8000_0000 + 32'(idx * 4); exp_err = 1'b0; end
      endcase
      do_cmd(0, addr, rdsel, wd, wm, rd, er, lat);
      exp_rd = (rdsel && !exp_err) ? model[idx] : 32'h0;
      checks++;
      if (er !== exp_err || lat !== 1) begin fails++; $display("FAIL rand_err[%0d] addr %h: got err %0b lat %0d expected %0b 1", n, addr, er, lat, exp_err); end
      checks++;
      if (rd !== exp_rd) begin fails++; $display("FAIL rand_rdata[%0d] addr %h: got %h expected %h", n, addr, rd, exp_rd); end
      if (!rdsel && !exp_err)
        for (int b = 0; b < 4; b++) if (wm[b]) model[idx][b*8 +: 8] = wd[b*8 +: 8];
    end
    checks++;
    if (spurious !== 0) begin fails++; $display("FAIL spurious_rsp: got %0d expected 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_wait_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
